// File: rtl/shift_deserializer.sv
// Serial-to-parallel word capture with selectable bit order and a one-word output hold.
// A completed word is held until acknowledged; bits arriving meanwhile raise a sticky overrun.
module shift_deserializer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       s,
  input  logic             start,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             word_ack,
  output logic [WIDTH-1:0] outputreg,
  output logic             word_valid,
  output logic             busy,
  output logic [CW-1:0]    bit_count,
  output logic             overrun
);

  typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             lsb_q, lsb_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] shifted;

  assign shifted = lsb_q ? {serial_in, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], serial_in};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    lsb_d   = lsb_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      StIdle: begin
        if (start && (s == 2'b01 || s == 2'b10)) begin
          lsb_d   = (s == 2'b01);
          shreg_d = '0;
          cnt_d   = '0;
          ovr_d   = 1'b0;
          state_d = StShift;
        end
      end
      StShift: begin
        // Abort wins over a bit arriving on the same edge.
        if (s == 2'b11) begin
          shreg_d = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end else if (bit_valid) begin
          shreg_d = shifted;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            out_d   = shifted;
            valid_d = 1'b1;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (bit_valid) begin
          ovr_d = 1'b1;
        end
        if (word_ack || s == 2'b11) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StShift);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      lsb_q   <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      lsb_q   <= lsb_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign outputreg  = out_q;
  assign word_valid = valid_q;
  assign busy       = busy_q;
  assign bit_count  = cnt_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer; completed words are checked by a queue-fed monitor.
module tb_shift_deserializer;

  localparam int W  = 16;
  localparam int CW = 5;

  logic          clk;
  logic          rst;
  logic [1:0]    s;
  logic          start;
  logic          serial_in;
  logic          bit_valid;
  logic          word_ack;
  logic [W-1:0]  outputreg;
  logic          word_valid;
  logic          busy;
  logic [CW-1:0] bit_count;
  logic          overrun;

  int total;
  int passed;
  logic [W-1:0] exp_q[$];

  shift_deserializer #(.WIDTH(W), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .s         (s),
    .start     (start),
    .serial_in (serial_in),
    .bit_valid (bit_valid),
    .word_ack  (word_ack),
    .outputreg (outputreg),
    .word_valid(word_valid),
    .busy      (busy),
    .bit_count (bit_count),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: every rising word_valid must match the oldest expected word.
  initial begin
    logic prev;
    logic [W-1:0] exp;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (word_valid && !prev) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_word: got %0h expected none", outputreg);
        end else begin
          exp = exp_q.pop_front();
          check("sb_word", {16'h0, outputreg}, {16'h0, exp});
        end
      end
      prev = word_valid;
    end
  end

  task automatic start_word(input logic [1:0] dir);
    s = dir; start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", {31'h0, busy}, 1);
    check("start_count", {27'h0, bit_count}, 0);
  endtask

  // Sends nbits of word in dir order; s is changed to during to show direction is latched.
  task automatic send_bits(input logic [1:0] dir, input logic [W-1:0] word, input int nbits,
                           input bit gaps, input logic [1:0] during);
    int i;
    int c;
    i = 0; c = 0;
    s = during;
    while (i < nbits) begin
      if (gaps && (c % 3 == 2)) begin
        bit_valid = 1'b0;
        tick();
        check("gap_count", {27'h0, bit_count}, i);
      end else begin
        bit_valid = 1'b1;
        serial_in = (dir == 2'b10) ? word[W-1-i] : word[i];
        tick();
        bit_valid = 1'b0;
        i++;
        if (i < W) check("step_count", {27'h0, bit_count}, i);
      end
      c++;
    end
  endtask

  initial begin
    total = 0; passed = 0;
    rst = 1'b0; s = 2'b00; start = 1'b0; serial_in = 1'b0; bit_valid = 1'b0; word_ack = 1'b0;
    #2;
    check("rst_out", {16'h0, outputreg}, 0);
    check("rst_flags", {29'h0, word_valid, busy, overrun}, 0);
    check("rst_count", {27'h0, bit_count}, 0);
    @(negedge clk);
    rst = 1'b1;

    // Start with s=00 or s=11 is ignored in IDLE.
    s = 2'b00; start = 1'b1; tick();
    check("start_s00_ignored", {31'h0, busy}, 0);
    s = 2'b11; tick();
    check("start_s11_ignored", {31'h0, busy}, 0);
    start = 1'b0;

    // MSB-first 0xA5C3.
    exp_q.push_back(16'hA5C3);
    start_word(2'b10);
    send_bits(2'b10, 16'hA5C3, W, 1'b0, 2'b00);
    check("msb_valid", {31'h0, word_valid}, 1);
    check("msb_busy", {31'h0, busy}, 0);
    check("msb_count", {27'h0, bit_count}, W);
    tick(); tick();
    check("hold_stable_valid", {31'h0, word_valid}, 1);
    check("hold_stable_out", {16'h0, outputreg}, 16'hA5C3);

    // Overrun in HOLD.
    bit_valid = 1'b1; serial_in = 1'b0; tick(); bit_valid = 1'b0;
    check("ovr_set", {31'h0, overrun}, 1);
    check("ovr_out", {16'h0, outputreg}, 16'hA5C3);
    check("ovr_valid", {31'h0, word_valid}, 1);
    word_ack = 1'b1; tick(); word_ack = 1'b0;
    check("ack_valid", {31'h0, word_valid}, 0);
    check("ack_count", {27'h0, bit_count}, 0);
    check("ack_ovr_sticky", {31'h0, overrun}, 1);
    word_ack = 1'b1; tick(); word_ack = 1'b0;
    check("idle_ack_out", {16'h0, outputreg}, 16'hA5C3);

    // LSB-first 0x1234 with gaps; s toggled to 10 mid-word.
    exp_q.push_back(16'h1234);
    start_word(2'b01);
    check("start_clears_ovr", {31'h0, overrun}, 0);
    send_bits(2'b01, 16'h1234, W, 1'b1, 2'b10);
    check("lsb_count", {27'h0, bit_count}, W);
    check("lsb_valid", {31'h0, word_valid}, 1);
    s = 2'b00; word_ack = 1'b1; tick(); word_ack = 1'b0;

    // Abort after 7 bits, with a bit on the same edge.
    start_word(2'b10);
    send_bits(2'b10, 16'hFFFF, 7, 1'b0, 2'b10);
    s = 2'b11; bit_valid = 1'b1; serial_in = 1'b1; tick(); bit_valid = 1'b0; s = 2'b00;
    check("abort_busy", {31'h0, busy}, 0);
    check("abort_count", {27'h0, bit_count}, 0);
    check("abort_valid", {31'h0, word_valid}, 0);
    check("abort_out", {16'h0, outputreg}, 16'h1234);

    // Async reset after 9 bits, then a full 0xFFFF word.
    start_word(2'b10);
    send_bits(2'b10, 16'h0000, 9, 1'b0, 2'b10);
    #2 rst = 1'b0;
    #1;
    check("arst_out", {16'h0, outputreg}, 0);
    check("arst_flags", {29'h0, word_valid, busy, overrun}, 0);
    check("arst_count", {27'h0, bit_count}, 0);
    #1 rst = 1'b1;
    exp_q.push_back(16'hFFFF);
    start_word(2'b10);
    send_bits(2'b10, 16'hFFFF, W, 1'b0, 2'b10);
    check("ffff_valid", {31'h0, word_valid}, 1);

    // start and word_ack together in HOLD: only the ack acts.
    s = 2'b10; start = 1'b1; word_ack = 1'b1; tick(); word_ack = 1'b0;
    check("simul_valid", {31'h0, word_valid}, 0);
    check("simul_busy", {31'h0, busy}, 0);
    tick();
    start = 1'b0;
    check("simul_restart_busy", {31'h0, busy}, 1);
    check("simul_out_kept", {16'h0, outputreg}, 16'hFFFF);

    // Another word, released from HOLD by s=11.
    exp_q.push_back(16'h00F1);
    send_bits(2'b10, 16'h00F1, W, 1'b0, 2'b01);
    s = 2'b11; tick(); s = 2'b00;
    check("s11_hold_valid", {31'h0, word_valid}, 0);
    check("s11_hold_out", {16'h0, outputreg}, 16'h00F1);

    tick(); tick();
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
